idc_image_ctrl: RTL and testbench
=================================

// Module: idc_image_ctrl
// PURPOSE
//   Image display controller directly downstream of the 8x8x8-bit image ROM.
//   After reset it streams all 64 pixels out of the ROM into a local buffer.
//   It then executes 3-bit commands on a 2x2 window around an operation point.
//   On the write-back command it dumps the buffer to the result RAM and pulses done.
// PARAMETERS
//   PIX_W    8   pixel width in bits
//   ADDR_W   6   pixel address width (64 pixels, row-major: A = {row[2:0], col[2:0]})
//   ROM_LAT  2   CLK cycles from driving IROM_A to sampling IROM_Q
// PORTS
//   CLK        in   1   clock, all state on posedge
//   RST_N      in   1   asynchronous active-low reset
//   cmd        in   3   command code (see BEHAVIOUR)
//   cmd_valid  in   1   command strobe; accepted only when busy==0
//   IROM_Q     in   8   ROM read data
//   IROM_CEN   out  1   ROM enable, active low
//   IROM_A     out  6   ROM address
//   IRB_RW     out  1   result RAM access: 0 = write, 1 = idle/read
//   IRB_A      out  6   result RAM address
//   IRB_D      out  8   result RAM write data
//   busy       out  1   high while loading, processing or writing back
//   done       out  1   one-cycle pulse after the last write-back beat
// BEHAVIOUR
//   Reset values: IROM_CEN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, busy=1, done=0.
//   Reset values (cont.): point (x,y)=(4,4), FSM=LOAD.
//   ROM timing: the ROM registers its address and then its data on negedge CLK.
//   Data for an address driven after posedge t is valid at posedge t+2.
//   The address is pipelined: one new address per cycle, data returns ROM_LAT cycles later.
//   FSM: LOAD -> IDLE -> (OP | WB) -> IDLE.
//   LOAD: CEN=0; A counts 0..63, one address per cycle. Pixel k is stored at posedge k+2.
//     CEN returns to 1 after A=63. LOAD->IDLE once pixel 63 is stored.
//     Pixel 63 is stored 65 cycles after reset release. busy stays 1 throughout LOAD.
//   IDLE: busy=0. cmd_valid=1 -> latch cmd. Code 0 -> WB; any other code -> OP.
//     cmd_valid in any other state is ignored; no queueing.
//   OP: one cycle, busy=1, then back to IDLE. Window = pixels (x-1,y-1),(x,y-1),(x-1,y),(x,y).
//     1 shift up    y=y-1 if y>1, else no change
//     2 shift down  y=y+1 if y<7, else no change
//     3 shift left  x=x-1 if x>1, else no change
//     4 shift right x=x+1 if x<7, else no change
//     5 average     all 4 window pixels <= (sum of the 4)>>2; 10-bit sum, no overflow
//     6 mirror X    swap the window's upper and lower rows
//     7 mirror Y    swap the window's left and right columns
//   WB: 64 beats. Beat k: IRB_RW=0, IRB_A=k, IRB_D=buf[k]. busy=1 throughout.
//     The cycle after beat 63: IRB_RW=1, done=1 for one cycle, FSM -> IDLE.
//     The buffer and the point are retained, so further commands and write-backs are legal.
//   Edge cases:
//     A shift at the border leaves the point unchanged and still takes one OP cycle.
//     cmd_valid held high: a new command is accepted on each IDLE cycle.
//     RST_N low mid-LOAD/OP/WB: immediate return to reset values, then a full reload.
//     No partial write-back completes after reset.
// CONFIGURATION
//   ROUND_AVG_EN defined:   average = (sum+2)>>2 (round half up).
//   ROUND_AVG_EN undefined: average = sum>>2 (truncate).
//   All other behaviour is identical.
// TESTING
//   Load timing: ROM holds pix[k]=k; release reset.
//     -> A=0..63 on consecutive cycles, busy falls 65 cycles after release.
//     -> Immediate WB writes IRB_D=k at IRB_A=k; done pulses once.
//   Border: from (4,4) issue up x4.
//     -> y becomes 3,2,1,1; the 4th shift changes nothing; each command gives busy=1 for one cycle.
//   Average: window {10,11,20,22}, cmd 5, then WB.
//     -> All 4 window addresses read 15 without ROUND_AVG_EN, 16 with it.
//     -> The other 60 pixels are unchanged.
//   Mirror: window {1,2,3,4} (UL,UR,LL,LR); cmd 6 -> {3,4,1,2}; then cmd 7 -> {4,3,2,1}.
//   Ignore/reset: cmd_valid pulsed during LOAD and during WB has no effect.
//     RST_N low at WB beat 30 -> IRB_RW=1 at once, LOAD restarts at A=0, no done pulse.
//   Saturation: all pixels 255, cmd 5 -> window stays 255 in both configs (sum=1020, no wrap).

Source files
------------

// File: rtl/idc_image_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : idc_image_ctrl                                                    |
// | Desc   : Loads an 8x8 image from ROM, applies 2x2-window commands and      |
// |          writes the image back to the result RAM. Optional: ROUND_AVG_EN   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module idc_image_ctrl #(
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 6,
  parameter int ROM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  input  logic [PIX_W-1:0]  IROM_Q,
  output logic              IROM_CEN,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              IRB_RW,
  output logic [ADDR_W-1:0] IRB_A,
  output logic [PIX_W-1:0]  IRB_D,
  output logic              busy,
  output logic              done
);

  localparam int c_NPIX  = 1 << ADDR_W;
  localparam int c_CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_OP   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PIX_W-1:0]   r_buf [c_NPIX];
  logic [c_CNT_W-1:0] r_iss_cnt;
  logic [ROM_LAT-1:0] r_vpipe;
  logic [ADDR_W-1:0]  r_apipe [ROM_LAT];
  logic [2:0]         r_x;
  logic [2:0]         r_y;
  logic [2:0]         r_cmd;
  logic [c_CNT_W-1:0] r_wb_cnt;

  logic               w_issue;
  logic               w_ld_store;
  logic [ADDR_W-1:0]  w_ld_addr;
  logic               w_ld_last;
  logic               w_wb_end;
  logic [ADDR_W-1:0]  w_a_ul;
  logic [ADDR_W-1:0]  w_a_ur;
  logic [ADDR_W-1:0]  w_a_ll;
  logic [ADDR_W-1:0]  w_a_lr;
  logic [PIX_W-1:0]   w_p_ul;
  logic [PIX_W-1:0]   w_p_ur;
  logic [PIX_W-1:0]   w_p_ll;
  logic [PIX_W-1:0]   w_p_lr;
  logic [PIX_W+1:0]   w_sum;
  logic [PIX_W+1:0]   w_sum_adj;
  logic [PIX_W-1:0]   w_avg;

  // Each ROM address travels down a ROM_LAT-deep tag pipe so its data lands at the right index
  assign w_issue    = (r_state == S_LOAD) && !r_iss_cnt[ADDR_W];
  assign w_ld_store = r_vpipe[ROM_LAT-1];
  assign w_ld_addr  = r_apipe[ROM_LAT-1];
  assign w_ld_last  = w_ld_store && (w_ld_addr == ADDR_W'(c_NPIX - 1));
  assign w_wb_end   = r_wb_cnt[ADDR_W];

  // Point is the lower-right pixel of the window; it never reaches row/col 0
  assign w_a_ul = {r_y - 3'd1, r_x - 3'd1};
  assign w_a_ur = {r_y - 3'd1, r_x};
  assign w_a_ll = {r_y,        r_x - 3'd1};
  assign w_a_lr = {r_y,        r_x};

  assign w_p_ul = r_buf[w_a_ul];
  assign w_p_ur = r_buf[w_a_ur];
  assign w_p_ll = r_buf[w_a_ll];
  assign w_p_lr = r_buf[w_a_lr];

  assign w_sum = {2'b00, w_p_ul} + {2'b00, w_p_ur} + {2'b00, w_p_ll} + {2'b00, w_p_lr};
`ifdef ROUND_AVG_EN
  assign w_sum_adj = w_sum + (PIX_W+2)'(2);
`else
  assign w_sum_adj = w_sum;
`endif
  assign w_avg = w_sum_adj[PIX_W+1:2];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    unique case (r_state)
      S_LOAD: begin
        if (w_ld_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        busy = 1'b0;
        if (cmd_valid) begin
          w_state_nxt = (cmd == 3'd0) ? S_WB : S_OP;
        end
      end
      S_OP: begin
        w_state_nxt = S_IDLE;
      end
      S_WB: begin
        if (w_wb_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IROM_CEN  <= 1'b1;
      IROM_A    <= '0;
      r_iss_cnt <= '0;
      r_vpipe   <= '0;
      r_x       <= 3'd4;
      r_y       <= 3'd4;
      r_cmd     <= 3'd0;
      r_wb_cnt  <= '0;
      IRB_RW    <= 1'b1;
      IRB_A     <= '0;
      IRB_D     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (w_issue) begin
        IROM_CEN  <= 1'b0;
        IROM_A    <= r_iss_cnt[ADDR_W-1:0];
        r_iss_cnt <= r_iss_cnt + 1'b1;
      end else begin
        IROM_CEN  <= 1'b1;
      end

      r_vpipe[0] <= w_issue;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end

      if ((r_state == S_IDLE) && cmd_valid) begin
        r_cmd    <= cmd;
        r_wb_cnt <= '0;
      end

      if (r_state == S_OP) begin
        case (r_cmd)
          3'd1: if (r_y > 3'd1) r_y <= r_y - 3'd1;
          3'd2: if (r_y < 3'd7) r_y <= r_y + 3'd1;
          3'd3: if (r_x > 3'd1) r_x <= r_x - 3'd1;
          3'd4: if (r_x < 3'd7) r_x <= r_x + 3'd1;
          default: ;
        endcase
      end

      // One beat per cycle; the cycle after the final beat releases the RAM and flags done
      if (r_state == S_WB) begin
        if (w_wb_end) begin
          IRB_RW <= 1'b1;
          done   <= 1'b1;
        end else begin
          IRB_RW   <= 1'b0;
          IRB_A    <= r_wb_cnt[ADDR_W-1:0];
          IRB_D    <= r_buf[r_wb_cnt[ADDR_W-1:0]];
          r_wb_cnt <= r_wb_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    r_apipe[0] <= r_iss_cnt[ADDR_W-1:0];
    for (int i = 1; i < ROM_LAT; i++) begin
      r_apipe[i] <= r_apipe[i-1];
    end

    if (w_ld_store) begin
      r_buf[w_ld_addr] <= IROM_Q;
    end

    if (r_state == S_OP) begin
      case (r_cmd)
        3'd5: begin
          r_buf[w_a_ul] <= w_avg;
          r_buf[w_a_ur] <= w_avg;
          r_buf[w_a_ll] <= w_avg;
          r_buf[w_a_lr] <= w_avg;
        end
        3'd6: begin
          r_buf[w_a_ul] <= w_p_ll;
          r_buf[w_a_ur] <= w_p_lr;
          r_buf[w_a_ll] <= w_p_ul;
          r_buf[w_a_lr] <= w_p_ur;
        end
        3'd7: begin
          r_buf[w_a_ul] <= w_p_ur;
          r_buf[w_a_ur] <= w_p_ul;
          r_buf[w_a_ll] <= w_p_lr;
          r_buf[w_a_lr] <= w_p_ll;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idc_image_ctrl.sv
`default_nettype none
// Testbench for idc_image_ctrl: negedge-registered ROM model, directed vector table
// of window commands checked through full write-backs, plus multi-cycle corner cases.
module tb_idc_image_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic       cmd_valid = 1'b0;
  logic [7:0] IROM_Q;
  logic       IROM_CEN;
  logic [5:0] IROM_A;
  logic       IRB_RW;
  logic [5:0] IRB_A;
  logic [7:0] IRB_D;
  logic       busy;
  logic       done;

  idc_image_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
    .IROM_CEN(IROM_CEN), .IROM_A(IROM_A), .IRB_RW(IRB_RW), .IRB_A(IRB_A),
    .IRB_D(IRB_D), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  logic [7:0] rom [64];
  logic [5:0] rom_a_r;
  always @(negedge CLK) begin
    rom_a_r <= IROM_A;
    IROM_Q  <= rom[rom_a_r];
  end

`ifdef ROUND_AVG_EN
  localparam int AVG1 = 25, AVG2 = 29, AVG_S = 16;
`else
  localparam int AVG1 = 24, AVG2 = 28, AVG_S = 15;
`endif

  typedef struct packed {
    logic [2:0]      cmd;
    logic [3:0][5:0] addr;
    logic [3:0][7:0] exp;
  } vec_t;
  vec_t vecs [9];

  int         n_chk = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic [7:0] cap [64];

  always @(posedge CLK) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setv(input int i, input logic [2:0] c, input int a0, input int a1,
                      input int a2, input int a3, input int e0, input int e1,
                      input int e2, input int e3);
    vecs[i].cmd = c;
    vecs[i].addr[0] = 6'(a0); vecs[i].addr[1] = 6'(a1);
    vecs[i].addr[2] = 6'(a2); vecs[i].addr[3] = 6'(a3);
    vecs[i].exp[0] = 8'(e0);  vecs[i].exp[1] = 8'(e1);
    vecs[i].exp[2] = 8'(e2);  vecs[i].exp[3] = 8'(e3);
  endtask

  task automatic rom_ramp();
    for (int k = 0; k < 64; k++) rom[k] = 8'(k);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) tick();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic issue_cmd(input logic [2:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("op_busy_hi", {31'd0, busy}, 32'd1);
    tick();
    chk("op_busy_lo", {31'd0, busy}, 32'd0);
  endtask

  // Write-back with optional mid-stream command pulse or reset at a given beat
  task automatic do_wb(input int pulse_beat, input int rst_beat, output int beats);
    int dc0, aerr;
    dc0 = done_cnt;
    beats = 0;
    aerr = 0;
    for (int k = 0; k < 64; k++) cap[k] = 'x;
    cmd = 3'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      cmd_valid = 1'b0;
      if (IRB_RW === 1'b0) begin
        if (IRB_A !== beats[5:0]) aerr++;
        if (busy !== 1'b1) aerr++;
        cap[IRB_A] = IRB_D;
        if (beats == pulse_beat) begin
          cmd = 3'd6;
          cmd_valid = 1'b1;
        end
        if (beats == rst_beat) begin
          #2 RST_N = 1'b0;
          #1;
          return;
        end
        beats++;
      end
    end
    chk("wb_order_busy", aerr, 0);
    chk("wb_beats", beats, 64);
    chk("wb_done_pulses", done_cnt - dc0, 1);
  endtask

  initial begin
    int aerr, nb, dc0;

    setv(0, 3'd6, 27, 28, 35, 36, 35, 36, 27, 28);
    setv(1, 3'd7, 27, 28, 35, 36, 36, 35, 28, 27);
    setv(2, 3'd1, 19, 20, 27, 28, 19, 20, 36, 35);
    setv(3, 3'd3, 18, 19, 26, 27, 18, 19, 26, 36);
    setv(4, 3'd6, 18, 19, 26, 27, 26, 36, 18, 19);
    setv(5, 3'd5, 18, 19, 26, 27, AVG1, AVG1, AVG1, AVG1);
    setv(6, 3'd2, 26, 27, 34, 35, AVG1, AVG1, 34, 28);
    setv(7, 3'd4, 27, 28, 35, 36, AVG1, 35, 28, 27);
    setv(8, 3'd5, 27, 28, 35, 36, AVG2, AVG2, AVG2, AVG2);

    // Reset values and load timing
    rom_ramp();
    RST_N = 1'b0;
    tick();
    chk("reset_vals", {8'd0, IROM_CEN, IROM_A, IRB_RW, IRB_A, IRB_D, busy, done},
        {8'd0, 1'b1, 6'd0, 1'b1, 6'd0, 8'd0, 1'b1, 1'b0});
    @(negedge CLK);
    RST_N = 1'b1;
    aerr = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (IROM_A !== 6'(k) || IROM_CEN !== 1'b0 || busy !== 1'b1) aerr++;
    end
    chk("load_addr_seq", aerr, 0);
    tick();
    chk("load_cen_off", {31'd0, IROM_CEN}, 32'd1);
    chk("load_busy_64", {31'd0, busy}, 32'd1);
    tick();
    chk("load_busy_65", {31'd0, busy}, 32'd0);

    do_wb(-1, -1, nb);
    aerr = 0;
    for (int k = 0; k < 64; k++) if (cap[k] !== 8'(k)) aerr++;
    chk("wb_identity", aerr, 0);

    // Vector table: each command followed by a full write-back
    do_reset();
    wait_idle("tbl_load");
    for (int i = 0; i < 9; i++) begin
      issue_cmd(vecs[i].cmd);
      do_wb(-1, -1, nb);
      for (int j = 0; j < 4; j++)
        chk($sformatf("vec%0d_px%0d", i, j), {24'd0, cap[vecs[i].addr[j]]},
            {24'd0, vecs[i].exp[j]});
    end

    // Borders: up x4 stops at y=1, right x4 stops at x=7
    do_reset();
    wait_idle("brd_load");
    repeat (4) issue_cmd(3'd1);
    issue_cmd(3'd6);
    repeat (4) issue_cmd(3'd4);
    issue_cmd(3'd7);
    do_wb(-1, -1, nb);
    chk("brd_up_ul", {24'd0, cap[3]},  32'd11);
    chk("brd_up_ur", {24'd0, cap[4]},  32'd12);
    chk("brd_up_ll", {24'd0, cap[11]}, 32'd3);
    chk("brd_up_lr", {24'd0, cap[12]}, 32'd4);
    chk("brd_rt_ul", {24'd0, cap[6]},  32'd7);
    chk("brd_rt_ur", {24'd0, cap[7]},  32'd6);
    chk("brd_rt_ll", {24'd0, cap[14]}, 32'd15);
    chk("brd_rt_lr", {24'd0, cap[15]}, 32'd14);

    // Average of {10,11,20,22}; remaining pixels untouched
    rom_ramp();
    rom[27] = 8'd10; rom[28] = 8'd11; rom[35] = 8'd20; rom[36] = 8'd22;
    do_reset();
    wait_idle("avg_load");
    issue_cmd(3'd5);
    do_wb(-1, -1, nb);
    chk("avg_ul", {24'd0, cap[27]}, AVG_S);
    chk("avg_ur", {24'd0, cap[28]}, AVG_S);
    chk("avg_ll", {24'd0, cap[35]}, AVG_S);
    chk("avg_lr", {24'd0, cap[36]}, AVG_S);
    aerr = 0;
    for (int k = 0; k < 64; k++)
      if (k != 27 && k != 28 && k != 35 && k != 36 && cap[k] !== 8'(k)) aerr++;
    chk("avg_others", aerr, 0);

    // Saturation
    for (int k = 0; k < 64; k++) rom[k] = 8'd255;
    do_reset();
    wait_idle("sat_load");
    issue_cmd(3'd5);
    do_wb(-1, -1, nb);
    chk("sat_ul", {24'd0, cap[27]}, 32'd255);
    chk("sat_lr", {24'd0, cap[36]}, 32'd255);

    // cmd_valid during LOAD is dropped
    rom_ramp();
    do_reset();
    aerr = 0;
    cmd = 3'd0;
    for (int i = 0; i < 72; i++) begin
      tick();
      cmd_valid = (i == 10);
      if (i >= 65 && (busy !== 1'b0 || IRB_RW !== 1'b1)) aerr++;
    end
    chk("ignore_load", aerr, 0);

    // cmd_valid during WB is dropped
    do_wb(10, -1, nb);
    do_wb(-1, -1, nb);
    chk("ignore_wb_27", {24'd0, cap[27]}, 32'd27);
    chk("ignore_wb_35", {24'd0, cap[35]}, 32'd35);

    // Reset at WB beat 30
    dc0 = done_cnt;
    do_wb(-1, 30, nb);
    chk("rst_wb_beat", nb, 30);
    chk("rst_wb_rw", {31'd0, IRB_RW}, 32'd1);
    chk("rst_wb_busy", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    chk("rst_reload_a", {26'd0, IROM_A}, 32'd0);
    chk("rst_reload_cen", {31'd0, IROM_CEN}, 32'd0);
    wait_idle("rst_reload_done");
    tick();
    chk("rst_no_done", done_cnt - dc0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
